// File: rtl/pu_vector_sequencer_if.sv
// Pixel-in / window-out handshake bundle for the img2col PU vector sequencer.
// slave = sequencer side, master = DMA / PU vector / MAC array side.
interface pu_vector_sequencer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDRESS_NUM = 5
);
  logic                   go;
  logic                   abort;
  logic [DATA_WIDTH-1:0]  s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic [5:0]             PU_No;
  logic [5:0]             round;
  logic [DATA_WIDTH-1:0]  new1;
  logic [ADDRESS_NUM-1:0] adrs_in1;
  logic [ADDRESS_NUM-1:0] adrs_in2;
  logic                   act;
  logic                   start;
  logic                   m_valid;
  logic                   m_ready;
  logic [5:0]             m_pu;
  logic                   m_last;
  logic                   busy;
  logic                   done;

  modport slave (
    input  go, abort, s_data, s_valid, m_ready,
    output s_ready, PU_No, round, new1, adrs_in1, adrs_in2,
    output act, start, m_valid, m_pu, m_last, busy, done
  );

  modport master (
    output go, abort, s_data, s_valid, m_ready,
    input  s_ready, PU_No, round, new1, adrs_in1, adrs_in2,
    input  act, start, m_valid, m_pu, m_last, busy, done
  );
endinterface

// File: rtl/pu_vector_sequencer.sv
// img2col PU vector controller: loads pixels into PU slots per round,
// pulses start, then walks the output mux handing each PU window to the MACs.
module pu_vector_sequencer #(
  parameter int ROW         = 28,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDRESS_NUM = 5,
  parameter int KERNEL      = 5,
  parameter int NUM_ROUNDS  = 24
) (
  input logic                  clk,
  input logic                  nrst,
  pu_vector_sequencer_if.slave bus
);

  localparam int WEIGHT_SIZE = KERNEL * KERNEL;
  localparam logic [5:0] LAST_PU  = 6'(ROW - 1);
  localparam logic [5:0] LAST_RND = 6'(NUM_ROUNDS - 1);
  localparam logic [ADDRESS_NUM-1:0] LAST_SLOT0 =
    ADDRESS_NUM'(WEIGHT_SIZE - 1);
  localparam logic [ADDRESS_NUM-1:0] LAST_SLOTN =
    ADDRESS_NUM'(KERNEL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_SEL,
    S_PRES,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [5:0]             r_pu_cnt;
  logic [ADDRESS_NUM-1:0] r_slot_cnt;
  logic [5:0]             r_round;
  logic [5:0]             r_pu_no;
  logic [DATA_WIDTH-1:0]  r_new1;
  logic [ADDRESS_NUM-1:0] r_adrs;
  logic                   r_act;
  logic                   r_start;
  logic                   r_s_ready;
  logic                   r_m_valid;
  logic [5:0]             r_m_pu;
  logic                   r_m_last;
  logic                   r_busy;
  logic                   r_done;

  logic [ADDRESS_NUM-1:0] w_last_slot;
  logic                   w_beat;

  // Neighbour shift supplies all but one column after round 0
  assign w_last_slot = (r_round == '0) ? LAST_SLOT0 : LAST_SLOTN;
  assign w_beat      = (r_state == S_LOAD) && r_s_ready && bus.s_valid;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_pu_cnt   <= '0;
      r_slot_cnt <= '0;
      r_round    <= '0;
      r_pu_no    <= '0;
      r_new1     <= '0;
      r_adrs     <= '0;
      r_act      <= 1'b0;
      r_start    <= 1'b0;
      r_s_ready  <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_pu     <= '0;
      r_m_last   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_act   <= 1'b0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      if (bus.abort) begin
        r_state    <= S_IDLE;
        r_pu_cnt   <= '0;
        r_slot_cnt <= '0;
        r_round    <= '0;
        r_s_ready  <= 1'b0;
        r_m_valid  <= 1'b0;
        r_m_last   <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (bus.go) begin
              r_state    <= S_LOAD;
              r_busy     <= 1'b1;
              r_s_ready  <= 1'b1;
              r_round    <= '0;
              r_pu_cnt   <= '0;
              r_slot_cnt <= '0;
            end
          end
          S_LOAD: begin
            if (w_beat) begin
              r_new1  <= bus.s_data;
              r_pu_no <= r_pu_cnt;
              r_adrs  <= r_slot_cnt;
              r_act   <= 1'b1;
              if (r_slot_cnt == w_last_slot) begin
                r_slot_cnt <= '0;
                if (r_pu_cnt == LAST_PU) begin
                  r_pu_cnt  <= '0;
                  r_s_ready <= 1'b0;
                  r_state   <= S_START;
                end else begin
                  r_pu_cnt <= r_pu_cnt + 6'd1;
                end
              end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
              end
            end
          end
          S_START: begin
            r_start  <= 1'b1;
            r_pu_cnt <= '0;
            r_pu_no  <= '0;
            r_state  <= S_SEL;
          end
          S_SEL: begin
            r_m_valid <= 1'b1;
            r_m_pu    <= r_pu_cnt;
            r_m_last  <= (r_pu_cnt == LAST_PU) &&
                         (r_round == LAST_RND);
            r_state   <= S_PRES;
          end
          S_PRES: begin
            if (bus.m_ready) begin
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              if (r_pu_cnt != LAST_PU) begin
                r_pu_cnt <= r_pu_cnt + 6'd1;
                r_pu_no  <= r_pu_cnt + 6'd1;
                r_state  <= S_SEL;
              end else if (r_round != LAST_RND) begin
                r_round    <= r_round + 6'd1;
                r_pu_cnt   <= '0;
                r_slot_cnt <= '0;
                r_s_ready  <= 1'b1;
                r_state    <= S_LOAD;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.s_ready  = r_s_ready;
  assign bus.PU_No    = r_pu_no;
  assign bus.round    = r_round;
  assign bus.new1     = r_new1;
  assign bus.adrs_in1 = r_adrs;
  assign bus.adrs_in2 = r_adrs;
  assign bus.act      = r_act;
  assign bus.start    = r_start;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_pu     = r_m_pu;
  assign bus.m_last   = r_m_last;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_pu_vector_sequencer.sv
// Randomised bench for pu_vector_sequencer against a pixel-queue /
// window-order reference model.
module tb_pu_vector_sequencer;

  localparam int ROW = 28;
  localparam int DW  = 16;
  localparam int AN  = 5;
  localparam int K   = 5;
  localparam int NR  = 24;

  logic clk;
  logic nrst;

  pu_vector_sequencer_if #(.DATA_WIDTH(DW), .ADDRESS_NUM(AN)) v ();

  pu_vector_sequencer #(
    .ROW(ROW), .DATA_WIDTH(DW), .ADDRESS_NUM(AN),
    .KERNEL(K), .NUM_ROUNDS(NR)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model state
  logic [DW-1:0] q[$];
  int wr_idx, exp_pu, m_round;
  int n_hs, n_start, n_done, n_last;
  int cyc, go_cyc, phase;
  int stall_left, n_act;
  bit stall_done, release_nxt, post_sel, chk702;
  bit abort_arm, post_abort;
  bit want_go, want_abort;

  function automatic int bpp(input int r);
    return (r == 0) ? K * K : K;
  endfunction

  task automatic mdl_clear();
    q.delete();
    wr_idx  = 0;
    exp_pu  = 0;
    m_round = 0;
  endtask

  task automatic monitor();
    logic [DW-1:0] e;
    if (post_sel) begin
      post_sel = 0;
      chk("rel_pu_no", v.PU_No, 6);
      chk("rel_mvalid", v.m_valid, 0);
    end
    if (post_abort) begin
      post_abort = 0;
      chk("abt_busy", v.busy, 0);
      chk("abt_mvalid", v.m_valid, 0);
      chk("abt_sready", v.s_ready, 0);
      chk("abt_round", v.round, 0);
    end
    if (v.act) begin
      chk("act_has_beat", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("new1", v.new1, e);
        chk("pu_no", v.PU_No, wr_idx / bpp(m_round));
        chk("adrs1", v.adrs_in1, wr_idx % bpp(m_round));
        chk("adrs2", v.adrs_in2, wr_idx % bpp(m_round));
        if (m_round == 0 && wr_idx == 99) begin
          chk("beat99_pu", v.PU_No, 3);
          chk("beat99_slot", v.adrs_in1, 24);
        end
        wr_idx++;
        n_act++;
      end
    end
    if (v.start) begin
      n_start++;
      chk("start_round", v.round, m_round);
      chk("start_beats", wr_idx, ROW * bpp(m_round));
      chk("start_qempty", q.size(), 0);
      if (m_round == 1) chk("r1_beats", wr_idx, 140);
      if (chk702 && m_round == 0) begin
        chk702 = 0;
        chk("start_cyc", cyc - go_cyc, 702);
      end
    end
    if (v.done) n_done++;
  endtask

  task automatic drive();
    int mode;
    v.go    = want_go;
    v.abort = want_abort;
    want_go    = 0;
    want_abort = 0;
    if (v.go) go_cyc = cyc;
    mode = (phase != 2) ? 0 : (m_round == 0) ? 0 : (m_round == 1) ? 1 : 2;
    case (mode)
      0: v.s_valid = 1'b1;
      1: v.s_valid = (cyc % 3 == 0);
      default: v.s_valid = 1'($urandom_range(0, 1));
    endcase
    v.s_data = DW'($urandom);
    if (phase == 2 && !stall_done && m_round == 0 &&
        v.m_valid && v.m_pu == 5) begin
      stall_done = 1;
      stall_left = 10;
    end
    if (stall_left > 0) begin
      v.m_ready = 1'b0;
      stall_left--;
      chk("stall_mvalid", v.m_valid, 1);
      chk("stall_mpu", v.m_pu, 5);
      chk("stall_pu_no", v.PU_No, 5);
      if (stall_left == 0) release_nxt = 1;
    end else if (release_nxt) begin
      release_nxt = 0;
      v.m_ready = 1'b1;
      post_sel = 1;
    end else if (phase == 2) begin
      v.m_ready = ($urandom_range(0, 3) != 0);
    end else begin
      v.m_ready = 1'b1;
    end
    if (abort_arm && m_round == 7 && v.m_valid) begin
      abort_arm  = 0;
      v.abort    = 1'b1;
      v.m_ready  = 1'b1;
      post_abort = 1;
    end
    // go while busy is ignored; only idle go restarts the model
    if (phase == 2 && v.busy && $urandom_range(0, 199) == 0)
      v.go = 1'b1;
    if (v.abort) begin
      mdl_clear();
    end else begin
      if (v.go && !v.busy) mdl_clear();
      if (v.s_valid && v.s_ready) q.push_back(v.s_data);
      if (v.m_valid && v.m_ready) begin
        n_hs++;
        chk("hs_mpu", v.m_pu, exp_pu);
        chk("hs_pu_no", v.PU_No, exp_pu);
        chk("hs_last", v.m_last,
            (exp_pu == ROW - 1 && m_round == NR - 1));
        if (v.m_last) n_last++;
        exp_pu++;
        if (exp_pu == ROW) begin
          exp_pu = 0;
          m_round++;
          wr_idx = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    drive();
  endtask

  task automatic chk_idle_outs(input string pfx);
    chk({pfx, "_sready"}, v.s_ready, 0);
    chk({pfx, "_busy"}, v.busy, 0);
    chk({pfx, "_act"}, v.act, 0);
    chk({pfx, "_start"}, v.start, 0);
    chk({pfx, "_mvalid"}, v.m_valid, 0);
    chk({pfx, "_done"}, v.done, 0);
    chk({pfx, "_round"}, v.round, 0);
    chk({pfx, "_pu_no"}, v.PU_No, 0);
    chk({pfx, "_new1"}, v.new1, 0);
    chk({pfx, "_mlast"}, v.m_last, 0);
  endtask

  initial begin
    int n;
    v.go = 0; v.abort = 0; v.s_data = '0;
    v.s_valid = 0; v.m_ready = 0;
    nrst = 1'b0;
    cyc = 0; phase = 0; stall_left = 0; n_act = 0;
    n_hs = 0; n_start = 0; n_done = 0; n_last = 0;
    stall_done = 0; release_nxt = 0; post_sel = 0; chk702 = 0;
    abort_arm = 0; post_abort = 0; want_go = 0; want_abort = 0;
    mdl_clear();
    repeat (3) @(negedge clk);
    chk_idle_outs("rst");
    nrst = 1'b1;

    // reset mid-LOAD
    phase = 1;
    want_go = 1;
    repeat (50) step();
    chk("midload_sready", v.s_ready, 1);
    nrst = 1'b0;
    #1;
    chk_idle_outs("midrst");
    mdl_clear();
    @(negedge clk);
    nrst = 1'b1;
    v.go = 0; v.s_valid = 0;

    // full map: round 0 dense, round 1 gapped, rest random
    phase = 2;
    n_hs = 0; n_start = 0; n_done = 0; n_last = 0;
    chk702 = 1;
    want_go = 1;
    n = 0;
    while (n_done == 0 && n < 60000) begin
      step();
      n++;
    end
    chk("map_timeout", n < 60000, 1);
    step();
    chk("after_done_busy", v.busy, 1'b0);
    chk("after_done_round", v.round, NR - 1);
    step();
    chk("map_handshakes", n_hs, ROW * NR);
    chk("map_starts", n_start, NR);
    chk("map_done", n_done, 1);
    chk("map_last", n_last, 1);
    chk("map_stall_seen", stall_done, 1);

    // abort during PRES of round 7
    phase = 3;
    abort_arm = 1;
    want_go = 1;
    n = 0;
    while ((abort_arm || post_abort) && n < 20000) begin
      step();
      n++;
    end
    chk("abort_timeout", n < 20000, 1);
    want_go = 1;
    want_abort = 1;
    step();
    step();
    chk("goabort_busy", v.busy, 0);
    chk("goabort_sready", v.s_ready, 0);
    want_go = 1;
    step();
    step();
    chk("restart_busy", v.busy, 1);
    chk("restart_sready", v.s_ready, 1);
    chk("restart_round", v.round, 0);
    n = 0;
    while (wr_idx < 30 && n < 200) begin
      step();
      n++;
    end
    chk("restart_writes", wr_idx >= 30, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
